// File: rtl/dbus_sram_responder.sv
// Single-outstanding data-bus SRAM responder with a programmable address-accept
// delay and a fixed read/write response latency.
package dbus_sram_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;
endpackage

module dbus_sram_responder
    import dbus_sram_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS  = 256,
    parameter int unsigned ADDR_DELAY   = 0,
    parameter int unsigned DATA_LATENCY = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp
);
    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        WAIT
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        hold_cnt_q, hold_cnt_d;
    logic [3:0]        lat_cnt_q, lat_cnt_d;
    logic [31:0]       rdata_q;
    logic [31:0]       dout_q;
    logic [31:0]       mem [DEPTH_WORDS];
    logic [IDX_W-1:0]  idx;
    logic              accept;
    logic              resp_fire;
    logic              is_write;
    logic              unused_ok;

    assign idx      = dreq.addr[IDX_W+1:2];
    assign is_write = (dreq.strobe != '0);
    assign unused_ok = ^{dreq.size, dreq.addr[31:IDX_W+2], dreq.addr[1:0]};

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        lat_cnt_d  = lat_cnt_q;
        accept     = 1'b0;
        resp_fire  = 1'b0;
        case (state_q)
            IDLE: begin
                if (dreq.valid) begin
                    if (ADDR_DELAY == 0) begin
                        accept = 1'b1;
                    end else begin
                        state_d    = HOLD;
                        hold_cnt_d = 3'd1;
                    end
                end
            end
            HOLD: begin
                if (!dreq.valid) begin
                    state_d    = IDLE;
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == 3'(ADDR_DELAY)) begin
                    accept = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + 3'd1;
                end
            end
            WAIT: begin
                if (lat_cnt_q == '0) begin
                    resp_fire = 1'b1;
                    state_d   = IDLE;
                end else begin
                    lat_cnt_d = lat_cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        // IDLE is also the reset state, so a zero-delay accept must be masked here.
        if (reset) begin
            accept = 1'b0;
        end
        if (accept) begin
            state_d    = WAIT;
            hold_cnt_d = '0;
            lat_cnt_d  = 4'(DATA_LATENCY - 1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            lat_cnt_q  <= '0;
            rdata_q    <= '0;
            dout_q     <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            lat_cnt_q  <= lat_cnt_d;
            if (accept) begin
                rdata_q <= is_write ? '0 : mem[idx];
            end
            if (resp_fire) begin
                dout_q <= rdata_q;
            end
        end
    end

    // Backing store is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (accept && is_write) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (dreq.strobe[b]) begin
                    mem[idx][8*b +: 8] <= dreq.data[8*b +: 8];
                end
            end
        end
    end

    assign dresp.addr_ok = accept;
    assign dresp.data_ok = resp_fire;
    assign dresp.data    = resp_fire ? rdata_q : dout_q;
endmodule

// File: tb/tb_dbus_sram_responder.sv
// Self-checking bench: three responder instances cover default timing, a long
// accept delay with latency 4, and reset mid-transaction with latency 5.
module tb_dbus_sram_responder;
    import dbus_sram_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, rst1, rst2;
    dbus_req_t  req0, req1, req2;
    dbus_resp_t resp0, resp1, resp2;

    dbus_sram_responder dut0 (.clk(clk), .reset(rst0), .dreq(req0), .dresp(resp0));
    dbus_sram_responder #(.ADDR_DELAY(3), .DATA_LATENCY(4))
        dut1 (.clk(clk), .reset(rst1), .dreq(req1), .dresp(resp1));
    dbus_sram_responder #(.DATA_LATENCY(5))
        dut2 (.clk(clk), .reset(rst2), .dreq(req2), .dresp(resp2));

    int total = 0;
    int bad   = 0;
    logic [31:0] sbq[$];

    typedef struct {
        string       name;
        bit          wr;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every data_ok from dut0 consumes the oldest expected word.
    always @(negedge clk) begin : sb_mon
        logic [31:0] e;
        if (!rst0 && resp0.data_ok) begin
            check("sb_overlap", 32'(resp0.addr_ok), 32'd0);
            if (sbq.size() == 0) begin
                check("sb_unexpected_data_ok", 32'(sbq.size()), 32'd1);
            end else begin
                e = sbq.pop_front();
                check("sb_data", resp0.data, e);
            end
        end
    end

    task automatic xact0(input vec_t v);
        @(posedge clk); #1;
        req0.valid  = 1'b1;
        req0.addr   = v.addr;
        req0.size   = 3'($urandom_range(0, 2));
        req0.strobe = v.wr ? v.strb : 4'h0;
        req0.data   = v.data;
        sbq.push_back(v.wr ? 32'h0 : v.exp);
        @(negedge clk);
        check({v.name, "_addr_ok"}, 32'(resp0.addr_ok), 32'd1);
        @(posedge clk); #1;
        req0.valid  = 1'b0;
        req0.strobe = 4'h0;
        @(negedge clk);
        check({v.name, "_data_ok"}, 32'(resp0.data_ok), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check({v.name, "_hold_ok"}, 32'(resp0.data_ok), 32'd0);
        check({v.name, "_hold_data"}, resp0.data, v.wr ? 32'h0 : v.exp);
    endtask

    // Drives dut1 valid from a per-cycle mask and checks the strobe timing.
    task automatic run1(input string nm, input logic [15:0] vmask, input int ncyc,
                        input int aok_c, input int dok_c, input logic [31:0] exp_data);
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk); #1;
            req1.valid = vmask[c];
            @(negedge clk);
            check($sformatf("%s_c%0d_addr_ok", nm, c), 32'(resp1.addr_ok), 32'(c == aok_c));
            check($sformatf("%s_c%0d_data_ok", nm, c), 32'(resp1.data_ok), 32'(c == dok_c));
            if (c == dok_c) check($sformatf("%s_data", nm), resp1.data, exp_data);
        end
    endtask

    task automatic xact2(input string nm, input bit wr, input logic [31:0] addr,
                         input logic [31:0] data, input logic [31:0] exp);
        @(posedge clk); #1;
        req2.valid  = 1'b1;
        req2.addr   = addr;
        req2.strobe = wr ? 4'hF : 4'h0;
        req2.data   = data;
        @(negedge clk);
        check({nm, "_addr_ok"}, 32'(resp2.addr_ok), 32'd1);
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            req2.valid  = 1'b0;
            req2.strobe = 4'h0;
            @(negedge clk);
            check($sformatf("%s_c%0d_data_ok", nm, c), 32'(resp2.data_ok), 32'(c == 5));
        end
        check({nm, "_data"}, resp2.data, wr ? 32'h0 : exp);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        req0 = '0; req1 = '0; req2 = '0;

        vecs.push_back('{"w10",     1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 32'h0});
        vecs.push_back('{"r10",     1'b0, 32'h0000_0010, 4'h0, 32'h0,         32'hDEAD_BEEF});
        vecs.push_back('{"w20",     1'b1, 32'h0000_0020, 4'hF, 32'h1122_3344, 32'h0});
        vecs.push_back('{"w20p",    1'b1, 32'h0000_0020, 4'h5, 32'hAABB_CCDD, 32'h0});
        vecs.push_back('{"r20",     1'b0, 32'h0000_0020, 4'h0, 32'h0,         32'h11BB_33DD});
        vecs.push_back('{"w404",    1'b1, 32'h0000_0404, 4'hF, 32'h5A5A_5A5A, 32'h0});
        vecs.push_back('{"r004",    1'b0, 32'h0000_0004, 4'h0, 32'h0,         32'h5A5A_5A5A});
        vecs.push_back('{"w3fc",    1'b1, 32'h0000_03FC, 4'hF, 32'h0102_0304, 32'h0});
        vecs.push_back('{"w3fcb3",  1'b1, 32'h0000_03FC, 4'h8, 32'hCC00_0000, 32'h0});
        vecs.push_back('{"r3fc",    1'b0, 32'h0000_03FC, 4'h0, 32'h0,         32'hCC02_0304});
        vecs.push_back('{"w13",     1'b1, 32'h0000_0013, 4'h2, 32'h0000_AB00, 32'h0});
        vecs.push_back('{"r11",     1'b0, 32'h0000_0011, 4'h0, 32'h0,         32'hDEAD_ABEF});
        vecs.push_back('{"rhialias", 1'b0, 32'hFFFF_F3FC, 4'h0, 32'h0,        32'hCC02_0304});

        @(negedge clk);
        check("rst_d0_addr_ok", 32'(resp0.addr_ok), 32'd0);
        check("rst_d0_data_ok", 32'(resp0.data_ok), 32'd0);
        check("rst_d0_data",    resp0.data,         32'h0);
        check("rst_d1_resp",    32'(resp1.addr_ok | resp1.data_ok), 32'd0);
        check("rst_d1_data",    resp1.data,         32'h0);
        check("rst_d2_data",    resp2.data,         32'h0);
        @(posedge clk); #1;
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;

        foreach (vecs[i]) xact0(vecs[i]);

        // Back-to-back: second request waits in the data_ok cycle, accepted one cycle later.
        @(posedge clk); #1;
        req0.valid = 1'b1; req0.addr = 32'h40; req0.strobe = 4'hF; req0.data = 32'h0BAD_F00D;
        sbq.push_back(32'h0);
        @(negedge clk);
        check("b2b_c0_addr_ok", 32'(resp0.addr_ok), 32'd1);
        @(posedge clk); #1;
        req0.strobe = 4'h0; req0.data = 32'h0;
        sbq.push_back(32'h0BAD_F00D);
        @(negedge clk);
        check("b2b_c1_data_ok", 32'(resp0.data_ok), 32'd1);
        check("b2b_c1_addr_ok", 32'(resp0.addr_ok), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("b2b_c2_addr_ok", 32'(resp0.addr_ok), 32'd1);
        @(posedge clk); #1;
        req0.valid = 1'b0;
        @(negedge clk);
        check("b2b_c3_data_ok", 32'(resp0.data_ok), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("sb_drained", 32'(sbq.size()), 32'd0);

        // Accept delay 3, latency 4, valid held through WAIT.
        req1.addr = 32'h8; req1.strobe = 4'hF; req1.data = 32'h1234_5678; req1.size = 3'd2;
        run1("t_delay", 16'h00FF, 10, 3, 7, 32'h0);
        // Valid drop in HOLD restarts the count.
        req1.strobe = 4'h0; req1.data = 32'h0;
        run1("t_drop", 16'h007B, 11, 6, 10, 32'h1234_5678);

        // Reset mid-transaction on the latency-5 instance.
        xact2("d2w34", 1'b1, 32'h34, 32'h7777_8888, 32'h0);
        xact2("d2r34", 1'b0, 32'h34, 32'h0,         32'h7777_8888);
        @(posedge clk); #1;
        req2.valid = 1'b1; req2.addr = 32'h30; req2.strobe = 4'hF; req2.data = 32'hCAFE_F00D;
        @(negedge clk);
        check("rmid_c0_addr_ok", 32'(resp2.addr_ok), 32'd1);
        @(posedge clk); #1;
        req2.valid = 1'b0; req2.strobe = 4'h0;
        @(negedge clk);
        check("rmid_c1_data_ok", 32'(resp2.data_ok), 32'd0);
        @(posedge clk); #1;
        rst2 = 1'b1;
        #1;
        check("rmid_c2_addr_ok", 32'(resp2.addr_ok), 32'd0);
        check("rmid_c2_data_ok", 32'(resp2.data_ok), 32'd0);
        check("rmid_c2_data",    resp2.data,         32'h0);
        @(posedge clk); #1;
        rst2 = 1'b0;
        for (int c = 3; c <= 8; c++) begin
            @(negedge clk);
            check($sformatf("rmid_c%0d_data_ok", c), 32'(resp2.data_ok), 32'd0);
            check($sformatf("rmid_c%0d_data", c),    resp2.data,         32'h0);
            @(posedge clk); #1;
        end
        xact2("rmid_r30", 1'b0, 32'h30, 32'h0, 32'hCAFE_F00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
